// File: rtl/pc_fetch_seq.sv
`default_nettype none
// ============================================================================
//  Module   : pc_fetch_seq
//  Purpose  : Multi-cycle fetch sequencer owning the PC, the IR and the
//             fetch handshake, with halt, fetch timeout and retire counter.
//  Revision : 1.0  initial release
// ============================================================================
module pc_fetch_seq #(
   parameter logic [29:0] RESET_PC = 30'h00000C00,
   parameter int          TIMEOUT  = 16,
   parameter int          CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   output logic             imem_req,
   output logic [29:0]      imem_addr,
   input  logic             imem_ready,
   input  logic [31:0]      imem_rdata,
   input  logic [29:0]      npc_in,
   input  logic             commit,
   input  logic             halt,
   output logic [29:0]      pc,
   output logic [31:0]      ir,
   output logic             ir_valid,
   output logic             halted,
   output logic             fetch_err,
   output logic [CNT_W-1:0] retired
);

   // Wait counter only has to count up to TIMEOUT-1.
   localparam int                WAIT_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] c_WAIT_LAST = WAIT_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_EXEC   = 3'd2,
      S_HALTED = 3'd3,
      S_ERROR  = 3'd4
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [WAIT_W-1:0] r_wait;
   logic [WAIT_W-1:0] w_wait_nxt;
   logic [29:0]       r_pc;
   logic [31:0]       r_ir;
   logic [CNT_W-1:0]  r_retired;
   logic              w_accept;
   logic              w_commit;

   always_comb begin
      w_state_nxt = r_state;
      w_wait_nxt  = r_wait;
      w_accept    = 1'b0;
      w_commit    = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_state_nxt = halt ? S_HALTED : S_FETCH;
         end
         S_FETCH: begin
            // halt is deliberately not looked at: an issued fetch always completes.
            if (imem_ready) begin
               w_accept    = 1'b1;
               w_wait_nxt  = '0;
               w_state_nxt = S_EXEC;
            end else if (r_wait == c_WAIT_LAST) begin
               w_wait_nxt  = '0;
               w_state_nxt = S_ERROR;
            end else begin
               w_wait_nxt  = r_wait + WAIT_W'(1);
            end
         end
         S_EXEC: begin
            if (commit) begin
               w_commit    = 1'b1;
               w_state_nxt = halt ? S_HALTED : S_FETCH;
            end
         end
         S_HALTED: begin
            if (!halt) begin
               w_state_nxt = S_FETCH;
            end
         end
         S_ERROR: begin
            w_state_nxt = S_ERROR;
         end
         default: begin
            w_state_nxt = S_ERROR;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_wait    <= '0;
         r_pc      <= RESET_PC;
         r_ir      <= '0;
         r_retired <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_wait  <= w_wait_nxt;
         if (w_accept) begin
            r_ir <= imem_rdata;
         end
         if (w_commit) begin
            r_pc      <= npc_in;
            r_retired <= r_retired + CNT_W'(1);
         end
      end
   end

   assign imem_req  = (r_state == S_FETCH);
   assign ir_valid  = (r_state == S_EXEC);
   assign halted    = (r_state == S_HALTED);
   assign fetch_err = (r_state == S_ERROR);
   assign imem_addr = r_pc;
   assign pc        = r_pc;
   assign ir        = r_ir;
   assign retired   = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_fetch_seq
//  Purpose  : Self-checking bench for pc_fetch_seq against a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pc_fetch_seq;

   localparam logic [29:0] c_RESET_PC = 30'h00000C00;
   localparam int          c_TIMEOUT  = 16;
   localparam int          c_CNT_W    = 32;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               imem_req;
   logic [29:0]        imem_addr;
   logic               imem_ready = 1'b0;
   logic [31:0]        imem_rdata = '0;
   logic [29:0]        npc_in = '0;
   logic               commit = 1'b0;
   logic               halt = 1'b0;
   logic [29:0]        pc;
   logic [31:0]        ir;
   logic               ir_valid;
   logic               halted;
   logic               fetch_err;
   logic [c_CNT_W-1:0] retired;

   int n_checks = 0;
   int n_err    = 0;

   pc_fetch_seq #(
      .RESET_PC (c_RESET_PC),
      .TIMEOUT  (c_TIMEOUT),
      .CNT_W    (c_CNT_W)
   ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ready (imem_ready),
      .imem_rdata (imem_rdata),
      .npc_in     (npc_in),
      .commit     (commit),
      .halt       (halt),
      .pc         (pc),
      .ir         (ir),
      .ir_valid   (ir_valid),
      .halted     (halted),
      .fetch_err  (fetch_err),
      .retired    (retired)
   );

   always #5 clk = ~clk;

   // Behavioural model: phase of the current instruction plus architectural values.
   typedef enum int {M_IDLE, M_FETCH, M_EXEC, M_HALT, M_ERR} mode_t;
   mode_t              m_mode;
   logic [29:0]        m_pc;
   logic [31:0]        m_ir;
   logic [c_CNT_W-1:0] m_ret;
   int                 m_misses;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_mode   <= M_IDLE;
         m_pc     <= c_RESET_PC;
         m_ir     <= '0;
         m_ret    <= '0;
         m_misses <= 0;
      end else begin
         case (m_mode)
            M_IDLE:  m_mode <= halt ? M_HALT : M_FETCH;
            M_FETCH: begin
               if (imem_ready) begin
                  m_ir     <= imem_rdata;
                  m_misses <= 0;
                  m_mode   <= M_EXEC;
               end else if (m_misses + 1 >= c_TIMEOUT) begin
                  m_mode   <= M_ERR;
               end else begin
                  m_misses <= m_misses + 1;
               end
            end
            M_EXEC: begin
               if (commit) begin
                  m_pc   <= npc_in;
                  m_ret  <= m_ret + 1;
                  m_mode <= halt ? M_HALT : M_FETCH;
               end
            end
            M_HALT:  if (!halt) m_mode <= M_FETCH;
            default: m_mode <= M_ERR;
         endcase
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("model.imem_req",  imem_req,  m_mode == M_FETCH);
      chk("model.imem_addr", imem_addr, m_pc);
      chk("model.pc",        pc,        m_pc);
      chk("model.ir",        ir,        m_ir);
      chk("model.ir_valid",  ir_valid,  m_mode == M_EXEC);
      chk("model.halted",    halted,    m_mode == M_HALT);
      chk("model.fetch_err", fetch_err, m_mode == M_ERR);
      chk("model.retired",   retired,   m_ret);
   end

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1; imem_ready = 1'b0; commit = 1'b0; halt = 1'b0;
      cyc();
      rst = 1'b0;
      cyc();   // IDLE -> FETCH edge has passed; now in first FETCH cycle
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      cyc(); cyc();
      chk("rst.imem_req", imem_req, 1'b0);
      chk("rst.pc", pc, 30'h00000C00);
      chk("rst.ir", ir, 32'h0);
      chk("rst.ir_valid", ir_valid, 1'b0);
      chk("rst.halted", halted, 1'b0);
      chk("rst.fetch_err", fetch_err, 1'b0);
      chk("rst.retired", retired, 0);

      // Basic fetch
      rst = 1'b0;
      cyc();
      chk("fetch.req", imem_req, 1'b1);
      chk("fetch.addr", imem_addr, 30'h00000C00);
      imem_ready = 1'b1; imem_rdata = 32'h3C010001;
      cyc();
      chk("fetch.ir", ir, 32'h3C010001);
      chk("fetch.ir_valid", ir_valid, 1'b1);

      // Commit / redirect
      imem_ready = 1'b0; commit = 1'b1; npc_in = 30'h00000C40;
      cyc();
      commit = 1'b0;
      chk("commit.pc", pc, 30'h00000C40);
      chk("commit.retired", retired, 1);
      chk("commit.addr", imem_addr, 30'h00000C40);
      chk("commit.req", imem_req, 1'b1);

      // Five wait states, accepted on the sixth cycle
      for (int i = 0; i < 5; i++) begin
         chk("wait.req", imem_req, 1'b1);
         chk("wait.addr", imem_addr, 30'h00000C40);
         cyc();
      end
      imem_ready = 1'b1; imem_rdata = 32'h8C220004;
      cyc();
      imem_ready = 1'b0;
      chk("wait.ir", ir, 32'h8C220004);
      chk("wait.ir_valid", ir_valid, 1'b1);
      chk("wait.err", fetch_err, 1'b0);

      // Halt in a commit cycle
      commit = 1'b1; halt = 1'b1; npc_in = 30'h00000D00;
      cyc();
      commit = 1'b0;
      chk("halt.halted", halted, 1'b1);
      chk("halt.pc", pc, 30'h00000D00);
      chk("halt.req", imem_req, 1'b0);
      cyc();
      chk("halt.stay", halted, 1'b1);
      halt = 1'b0;
      cyc();
      chk("unhalt.req", imem_req, 1'b1);
      chk("unhalt.addr", imem_addr, 30'h00000D00);
      // halt during FETCH is ignored
      halt = 1'b1; imem_ready = 1'b1; imem_rdata = 32'h00000020;
      cyc();
      chk("haltfetch.ir_valid", ir_valid, 1'b1);
      chk("haltfetch.halted", halted, 1'b0);
      halt = 1'b0; imem_ready = 1'b0;

      // Randomized traffic with occasional resets
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 299) == 0) begin
            rst = 1'b1; cyc(); rst = 1'b0;
         end
         imem_ready = ($urandom_range(0, 3) != 0);
         imem_rdata = $urandom;
         npc_in     = 30'($urandom);
         commit     = $urandom_range(0, 1) == 1;
         halt       = $urandom_range(0, 9) == 0;
         cyc();
      end

      // Timeout: exactly TIMEOUT missed cycles end in ERROR
      do_reset();
      for (int i = 0; i < c_TIMEOUT - 1; i++) cyc();
      chk("tmo.before_req", imem_req, 1'b1);
      chk("tmo.before_err", fetch_err, 1'b0);
      cyc();
      chk("tmo.err", fetch_err, 1'b1);
      chk("tmo.req", imem_req, 1'b0);
      for (int i = 0; i < 100; i++) begin
         imem_ready = $urandom_range(0, 1) == 1;
         commit     = $urandom_range(0, 1) == 1;
         halt       = $urandom_range(0, 1) == 1;
         npc_in     = 30'($urandom);
         cyc();
      end
      chk("tmo.sticky", fetch_err, 1'b1);
      chk("tmo.retired", retired, 0);
      rst = 1'b1;
      #1;
      chk("tmo.cleared", fetch_err, 1'b0);

      // Ready on the TIMEOUT-th cycle is still accepted
      do_reset();
      for (int i = 0; i < c_TIMEOUT - 1; i++) cyc();
      imem_ready = 1'b1; imem_rdata = 32'hDEADBEEF;
      cyc();
      imem_ready = 1'b0;
      chk("edge.ir_valid", ir_valid, 1'b1);
      chk("edge.ir", ir, 32'hDEADBEEF);
      chk("edge.err", fetch_err, 1'b0);

      // Wrap of pc through npc_in, then asynchronous reset mid-fetch
      commit = 1'b1; npc_in = 30'h3FFFFFFF;
      cyc();
      commit = 1'b0;
      chk("wrap.pc", pc, 30'h3FFFFFFF);
      chk("wrap.retired", retired, 1);
      chk("wrap.req", imem_req, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk("midrst.req", imem_req, 1'b0);
      chk("midrst.pc", pc, 30'h00000C00);
      chk("midrst.retired", retired, 0);
      cyc();
      rst = 1'b0;
      cyc(); cyc();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pc_fetch_seq.md
Name: pc_fetch_seq

Overview:
Multi-cycle fetch sequencer that owns the program counter and sequences the next-PC unit.
- Issues word-addressed instruction-memory requests and latches the returned instruction into the IR.
- Holds the instruction until the datapath signals commit, then loads the PC from the next-PC unit's output (npc_in).
- Sits between instruction memory, the next-PC logic and the execute datapath of the multi-cycle core.
- Provides halt, fetch-timeout error detection and a retired-instruction counter.

Parameters:
RESET_PC, 30'h00000C00, word address loaded into pc on reset (byte address 0x00003000).
TIMEOUT, 16, maximum number of FETCH cycles without imem_ready before an error is raised (must be ≥1).
CNT_W, 32, width of the retired-instruction counter.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
imem_req  output  1  instruction fetch request.
imem_addr  output  30  word address [31:2] for the fetch; always equals pc.
imem_ready  input  1  memory reports that imem_rdata is valid this cycle.
imem_rdata  input  32  instruction word returned by memory.
npc_in  input  30  next PC [31:2] from the next-PC unit; sampled only on an accepted commit.
commit  input  1  datapath has finished the current instruction.
halt  input  1  request to stop fetching after the current instruction.
pc  output  30  current PC [31:2]; feeds the next-PC unit.
ir  output  32  latched instruction.
ir_valid  output  1  ir holds an instruction awaiting commit.
halted  output  1  sequencer is in the HALTED state.
fetch_err  output  1  sticky fetch-timeout error flag.
retired  output  CNT_W  count of committed instructions.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-fetch):
  - pc=RESET_PC, ir=0, ir_valid=0, imem_req=0, halted=0, fetch_err=0, retired=0, wait counter=0, state=IDLE.
- Output timing: imem_req, halted and ir_valid are decoded from the registered state only; none depends combinationally on an input. imem_addr is wired to pc.
- States:
  - IDLE: for the single cycle after reset release. If halt=1, go to HALTED; otherwise go to FETCH.
  - FETCH: imem_req=1.
    - If imem_ready=1: ir<=imem_rdata, wait counter<=0, go to EXEC.
    - Otherwise the wait counter increments. When the counter reaches TIMEOUT-1 with imem_ready still 0, go to ERROR.
    - halt is ignored in FETCH; an issued request is never abandoned.
  - EXEC: ir_valid=1, imem_req=0.
    - On commit=1: pc<=npc_in, retired<=retired+1 (wraps modulo 2^CNT_W).
    - After that commit, go to HALTED if halt=1 in the same cycle; otherwise go to FETCH.
  - HALTED: halted=1, imem_req=0. When halt=0, go to FETCH. pc is unchanged.
  - ERROR: fetch_err=1, imem_req=0. Left only by reset.
- commit is ignored in every state except EXEC. pc, ir and retired change only as stated above.
- Handshake: imem_addr is stable for every cycle that imem_req=1. imem_ready while imem_req=0 is ignored.
- ir keeps its value after commit. ir_valid is the only qualifier of ir.
- Latency: minimum 2 cycles per instruction (FETCH with imem_ready=1, then EXEC with commit=1). The next request is issued in the cycle after the commit.
- npc_in is taken as given: no alignment or range checks. Wrap from 30'h3FFFFFFF to 0 is legal.
- TIMEOUT window: exactly TIMEOUT FETCH cycles without imem_ready end in ERROR. imem_ready arriving on the TIMEOUT-th cycle is accepted.

Test Plan:
- Reset then basic fetch: release rst, imem_ready=1 in the first FETCH cycle, rdata=32'h3C010001 → imem_addr=30'h00000C00; the next cycle has ir=32'h3C010001 and ir_valid=1.
- Commit/redirect: in EXEC, commit=1 with npc_in=30'h00000C40 → pc=30'h00000C40, retired=1. The next FETCH has imem_addr=30'h00000C40.
- Wait states: imem_ready low for 5 cycles, then high → imem_req and imem_addr stable for all 6 cycles; no error; ir latched on the 6th cycle.
- Timeout: TIMEOUT=16, imem_ready held 0 → after 16 FETCH cycles, fetch_err=1 and imem_req=0. fetch_err stays 1 for 100 cycles and clears only on rst.
- Halt: halt=1 in a commit cycle → halted=1 next cycle, pc=npc_in, no request. Drop halt → FETCH from npc_in. halt=1 during FETCH → fetch completes and goes to EXEC.
- Mid-fetch reset: assert rst while in FETCH with imem_req=1 → imem_req=0 immediately (before the next edge), pc=30'h00000C00, retired=0.
